// File: rtl/player_link_pkg.sv
// Shared definitions for the player link exchanger.
//
// Contents:
//   SyncDefault  - default frame start byte
//   tx_state_e   - transmit FSM encoding
//   rx_state_e   - receive FSM encoding
//   idx_width()  - width of a byte index able to count 0..bytes

package player_link_pkg;

    localparam logic [7:0] SyncDefault = 8'hA5;

    typedef enum logic [2:0] {
        TGap  = 3'd0,
        TSync = 3'd1,
        TData = 3'd2,
        TCsum = 3'd3,
        TWait = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        RHunt = 2'd0,
        RData = 2'd1,
        RCsum = 2'd2,
        RWait = 2'd3
    } rx_state_e;

    function automatic int unsigned idx_width(input int unsigned bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage

// File: rtl/player_link_wdt.sv
// Saturating link watchdog.
//
// Counts clk cycles since the last reload and saturates at TIMEOUT_CYC.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (count cleared)
//   reload_i   restart the count from zero
//   expired_o  the count will sit at TIMEOUT_CYC after the coming edge

module player_link_wdt #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload_i,
    output logic expired_o
);

    localparam int unsigned     CntW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYC);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = '0;
        end else if (cnt_q != Limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looking at the next count lets the registered link_up in the parent drop
    // on the same edge the counter reaches the limit.
    assign expired_o = (cnt_d == Limit);

endmodule

// File: rtl/player_link_xchg.sv
// Multi-byte player state exchanger over a UART FIFO pair.
//
// TX: every TX_GAP idle cycles, snapshot p1_in_data and send SYNC, payload
// bytes 0..BYTES-1 (and a XOR checksum byte when PLAYER_LINK_CSUM_EN is
// defined). Each write is followed by one wait cycle so tx_full can settle.
// RX: hunt for SYNC, gather BYTES payload bytes into a shadow register and
// commit them atomically to p2_out_data. A watchdog drops link_up when no
// good frame arrives for TIMEOUT_CYC cycles.
//
// Build option: define PLAYER_LINK_CSUM_EN to add the checksum byte on both
// sides and enable frame_err; otherwise frame_err is tied low.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   p1_in_data           local player state, byte 0 = [7:0]
//   p1_out_data          snapshot of the frame being / last transmitted
//   tx_full              TX FIFO full
//   wr_uart, w_data      TX FIFO write strobe and data
//   r_data, rx_empty     RX FIFO head byte and empty flag
//   rd_uart              RX FIFO pop strobe
//   p2_out_data          last good remote payload
//   p2_valid             one-cycle pulse when p2_out_data updates
//   link_up              good frame seen within TIMEOUT_CYC
//   frame_err            one-cycle pulse on checksum mismatch

module player_link_xchg
    import player_link_pkg::*;
#(
    parameter int unsigned BYTES       = 2,
    parameter logic [7:0]  SYNC        = SyncDefault,
    parameter int unsigned TX_GAP      = 1000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*BYTES-1:0] p1_in_data,
    output logic [8*BYTES-1:0] p1_out_data,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [7:0]         w_data,
    input  logic [7:0]         r_data,
    input  logic               rx_empty,
    output logic               rd_uart,
    output logic [8*BYTES-1:0] p2_out_data,
    output logic               p2_valid,
    output logic               link_up,
    output logic               frame_err
);

    localparam int unsigned     IdxW    = idx_width(BYTES);
    localparam int unsigned     GapW    = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(TX_GAP - 1);

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    tx_state_e                 tx_state_q, tx_state_d;
    tx_state_e                 tx_next_q, tx_next_d;
    logic [GapW-1:0]           gap_q, gap_d;
    logic [IdxW-1:0]           tx_idx_q, tx_idx_d;
    logic [BYTES-1:0][7:0]     snap_q, snap_d;
    logic                      wr_q, wr_d;
    logic [7:0]                w_data_q, w_data_d;
    logic [7:0]                tx_byte;

    always_comb begin
        tx_byte = 8'h00;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (tx_idx_q == IdxW'(i)) begin
                tx_byte = snap_q[i];
            end
        end
    end

`ifdef PLAYER_LINK_CSUM_EN
    logic [7:0] tx_csum;

    always_comb begin
        tx_csum = 8'h00;
        for (int unsigned i = 0; i < BYTES; i++) begin
            tx_csum = tx_csum ^ snap_q[i];
        end
    end
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_next_d  = tx_next_q;
        gap_d      = gap_q;
        tx_idx_d   = tx_idx_q;
        snap_d     = snap_q;
        wr_d       = 1'b0;
        w_data_d   = w_data_q;

        unique case (tx_state_q)
            TGap: begin
                if (gap_q == GapLast) begin
                    gap_d      = '0;
                    snap_d     = p1_in_data;
                    tx_state_d = TSync;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            TSync: begin
                if (!tx_full) begin
                    wr_d       = 1'b1;
                    w_data_d   = SYNC;
                    tx_idx_d   = '0;
                    tx_next_d  = TData;
                    tx_state_d = TWait;
                end
            end
            TData: begin
                if (!tx_full) begin
                    wr_d       = 1'b1;
                    w_data_d   = tx_byte;
                    tx_state_d = TWait;
                    if (tx_idx_q == LastIdx) begin
`ifdef PLAYER_LINK_CSUM_EN
                        tx_next_d = TCsum;
`else
                        tx_next_d = TGap;
`endif
                    end else begin
                        tx_idx_d  = tx_idx_q + 1'b1;
                        tx_next_d = TData;
                    end
                end
            end
            TCsum: begin
`ifdef PLAYER_LINK_CSUM_EN
                if (!tx_full) begin
                    wr_d       = 1'b1;
                    w_data_d   = tx_csum;
                    tx_next_d  = TGap;
                    tx_state_d = TWait;
                end
`else
                tx_state_d = TGap;
`endif
            end
            TWait: begin
                tx_state_d = tx_next_q;
            end
            default: begin
                tx_state_d = TGap;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TGap;
            tx_next_q  <= TGap;
            gap_q      <= '0;
            tx_idx_q   <= '0;
            snap_q     <= '0;
            wr_q       <= 1'b0;
            w_data_q   <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_next_q  <= tx_next_d;
            gap_q      <= gap_d;
            tx_idx_q   <= tx_idx_d;
            snap_q     <= snap_d;
            wr_q       <= wr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign p1_out_data = snap_q;
    assign wr_uart     = wr_q;
    assign w_data      = w_data_q;

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    rx_state_e                 rx_state_q, rx_state_d;
    rx_state_e                 rx_ret_q, rx_ret_d;
    logic [IdxW-1:0]           rx_idx_q, rx_idx_d;
    logic [BYTES-1:0][7:0]     shadow_q, shadow_d;
    logic [BYTES-1:0][7:0]     p2_q, p2_d;
    logic                      p2_valid_q, p2_valid_d;
    logic                      rd_q, rd_d;
    logic                      link_q, link_d;
    logic                      commit;
    logic                      wdt_expired;

`ifdef PLAYER_LINK_CSUM_EN
    logic [7:0] rx_xor_q, rx_xor_d;
    logic       frame_err_q, frame_err_d;
`endif

    always_comb begin
        rx_state_d = rx_state_q;
        rx_ret_d   = rx_ret_q;
        rx_idx_d   = rx_idx_q;
        shadow_d   = shadow_q;
        p2_d       = p2_q;
        p2_valid_d = 1'b0;
        rd_d       = 1'b0;
        link_d     = link_q;
        commit     = 1'b0;
`ifdef PLAYER_LINK_CSUM_EN
        rx_xor_d    = rx_xor_q;
        frame_err_d = 1'b0;
`endif

        unique case (rx_state_q)
            RHunt: begin
                if (!rx_empty) begin
                    rd_d       = 1'b1;
                    rx_state_d = RWait;
                    if (r_data == SYNC) begin
                        rx_idx_d = '0;
`ifdef PLAYER_LINK_CSUM_EN
                        rx_xor_d = 8'h00;
`endif
                        rx_ret_d = RData;
                    end else begin
                        rx_ret_d = RHunt;
                    end
                end
            end
            RData: begin
                if (!rx_empty) begin
                    rd_d       = 1'b1;
                    rx_state_d = RWait;
                    for (int unsigned i = 0; i < BYTES; i++) begin
                        if (rx_idx_q == IdxW'(i)) begin
                            shadow_d[i] = r_data;
                        end
                    end
`ifdef PLAYER_LINK_CSUM_EN
                    rx_xor_d = rx_xor_q ^ r_data;
`endif
                    if (rx_idx_q == LastIdx) begin
`ifdef PLAYER_LINK_CSUM_EN
                        rx_ret_d = RCsum;
`else
                        commit   = 1'b1;
                        rx_ret_d = RHunt;
`endif
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                        rx_ret_d = RData;
                    end
                end
            end
            RCsum: begin
`ifdef PLAYER_LINK_CSUM_EN
                if (!rx_empty) begin
                    rd_d       = 1'b1;
                    rx_state_d = RWait;
                    rx_ret_d   = RHunt;
                    if (r_data == rx_xor_q) begin
                        commit = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
`else
                rx_state_d = RHunt;
`endif
            end
            RWait: begin
                rx_state_d = rx_ret_q;
            end
            default: begin
                rx_state_d = RHunt;
            end
        endcase

        // A commit in the same cycle as expiry keeps the link up.
        if (commit) begin
            p2_d       = shadow_d;
            p2_valid_d = 1'b1;
            link_d     = 1'b1;
        end else if (wdt_expired) begin
            link_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RHunt;
            rx_ret_q   <= RHunt;
            rx_idx_q   <= '0;
            shadow_q   <= '0;
            p2_q       <= '0;
            p2_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            link_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_ret_q   <= rx_ret_d;
            rx_idx_q   <= rx_idx_d;
            shadow_q   <= shadow_d;
            p2_q       <= p2_d;
            p2_valid_q <= p2_valid_d;
            rd_q       <= rd_d;
            link_q     <= link_d;
        end
    end

`ifdef PLAYER_LINK_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_xor_q    <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            rx_xor_q    <= rx_xor_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign p2_out_data = p2_q;
    assign p2_valid    = p2_valid_q;
    assign rd_uart     = rd_q;
    assign link_up     = link_q;

    player_link_wdt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdt (
        .clk      (clk),
        .rst      (rst),
        .reload_i (commit),
        .expired_o(wdt_expired)
    );

endmodule
